// File: rtl/id_fwd_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// id_fwd_pipe: decode-operand resolve with N-source forwarding, load-use
// stall, flush and a saturating stall counter, registered into ID/EX.
// Revision: 1.0
// ----------------------------------------------------------------------------
module id_fwd_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int N_FWD  = 2,
   parameter int OP_W   = 8,
   parameter int SEL_W  = 3,
   parameter int CNT_W  = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic                      i_reg_0_ren,
   input  logic                      i_reg_1_ren,
   input  logic [ADDR_W-1:0]         i_reg_0_addr,
   input  logic [ADDR_W-1:0]         i_reg_1_addr,
   input  logic [DATA_W-1:0]         i_reg_0_data,
   input  logic [DATA_W-1:0]         i_reg_1_data,
   input  logic [DATA_W-1:0]         i_imm,
   input  logic [OP_W-1:0]           i_alu_op,
   input  logic [SEL_W-1:0]          i_alu_sel,
   input  logic                      i_reg_wen,
   input  logic [ADDR_W-1:0]         i_reg_waddr,
   input  logic [N_FWD-1:0]          i_fwd_wen,
   input  logic [N_FWD*ADDR_W-1:0]   i_fwd_waddr,
   input  logic [N_FWD*DATA_W-1:0]   i_fwd_wdata,
   input  logic [N_FWD-1:0]          i_fwd_pend,
   input  logic                      i_flush,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [OP_W-1:0]           o_alu_op,
   output logic [SEL_W-1:0]          o_alu_sel,
   output logic [DATA_W-1:0]         o_op_reg_0,
   output logic [DATA_W-1:0]         o_op_reg_1,
   output logic                      o_reg_wen,
   output logic [ADDR_W-1:0]         o_reg_waddr,
   output logic                      o_hazard,
   output logic [CNT_W-1:0]          o_stall_cnt
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   logic              r_valid;
   logic [OP_W-1:0]   r_alu_op;
   logic [SEL_W-1:0]  r_alu_sel;
   logic [DATA_W-1:0] r_op_0;
   logic [DATA_W-1:0] r_op_1;
   logic              r_reg_wen;
   logic [ADDR_W-1:0] r_reg_waddr;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic [DATA_W-1:0] w_op_0;
   logic [DATA_W-1:0] w_op_1;
   logic              w_haz_0;
   logic              w_haz_1;
   logic              w_hazard;
   logic              w_ready;
   logic              w_accept;

   // Returns {hazard, data}. Scanning oldest to youngest lets the youngest
   // matching source overwrite, so an older source can never win.
   function automatic logic [DATA_W:0] f_resolve(
      input logic                    ren,
      input logic [ADDR_W-1:0]       addr,
      input logic [DATA_W-1:0]       rdata,
      input logic [DATA_W-1:0]       imm,
      input logic [N_FWD-1:0]        fwen,
      input logic [N_FWD*ADDR_W-1:0] fwaddr,
      input logic [N_FWD*DATA_W-1:0] fwdata,
      input logic [N_FWD-1:0]        fpend
   );
      logic [DATA_W:0] res;
      res = {1'b0, rdata};
      for (int k = N_FWD - 1; k >= 0; k--) begin
         if (fwen[k] && (fwaddr[k*ADDR_W +: ADDR_W] == addr)) begin
            res = {fpend[k], fwdata[k*DATA_W +: DATA_W]};
         end
      end
      if (!ren) begin
         res = {1'b0, imm};
      end else if (addr == '0) begin
         res = '0;
      end
      return res;
   endfunction

   always_comb begin
      {w_haz_0, w_op_0} = f_resolve(i_reg_0_ren, i_reg_0_addr, i_reg_0_data, i_imm,
                                    i_fwd_wen, i_fwd_waddr, i_fwd_wdata, i_fwd_pend);
      {w_haz_1, w_op_1} = f_resolve(i_reg_1_ren, i_reg_1_addr, i_reg_1_data, i_imm,
                                    i_fwd_wen, i_fwd_waddr, i_fwd_wdata, i_fwd_pend);
   end

   assign w_hazard = i_valid & (w_haz_0 | w_haz_1);
   assign w_ready  = (~r_valid | i_ready) & ~w_hazard & ~i_flush;
   assign w_accept = i_valid & w_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid     <= 1'b0;
         r_alu_op    <= '0;
         r_alu_sel   <= '0;
         r_op_0      <= '0;
         r_op_1      <= '0;
         r_reg_wen   <= 1'b0;
         r_reg_waddr <= '0;
      end else if (i_flush || (!w_accept && r_valid && i_ready)) begin
         // Flush and drain both leave a zeroed bubble behind.
         r_valid     <= 1'b0;
         r_alu_op    <= '0;
         r_alu_sel   <= '0;
         r_op_0      <= '0;
         r_op_1      <= '0;
         r_reg_wen   <= 1'b0;
         r_reg_waddr <= '0;
      end else if (w_accept) begin
         r_valid     <= 1'b1;
         r_alu_op    <= i_alu_op;
         r_alu_sel   <= i_alu_sel;
         r_op_0      <= w_op_0;
         r_op_1      <= w_op_1;
         r_reg_wen   <= i_reg_wen;
         r_reg_waddr <= i_reg_waddr;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= '0;
      end else if (i_valid && !w_accept && !i_flush && (r_stall_cnt != c_CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign o_ready     = w_ready;
   assign o_hazard    = w_hazard;
   assign o_valid     = r_valid;
   assign o_alu_op    = r_alu_op;
   assign o_alu_sel   = r_alu_sel;
   assign o_op_reg_0  = r_op_0;
   assign o_op_reg_1  = r_op_1;
   assign o_reg_wen   = r_reg_wen;
   assign o_reg_waddr = r_reg_waddr;
   assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_fwd_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_id_fwd_pipe: scoreboard bench for id_fwd_pipe (default and CNT_W=2).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_id_fwd_pipe;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int N_FWD  = 2;
   localparam int OP_W   = 8;
   localparam int SEL_W  = 3;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] r0;
      logic [DATA_W-1:0] r1;
      logic              wen;
      logic [ADDR_W-1:0] waddr;
   } pl_t;

   logic clk = 1'b0;
   logic rst_n;
   logic valid, ready_out, ren0, ren1, reg_wen, flush, ex_ready;
   logic [ADDR_W-1:0] addr0, addr1, reg_waddr;
   logic [DATA_W-1:0] data0, data1, imm;
   logic [OP_W-1:0]   alu_op;
   logic [SEL_W-1:0]  alu_sel;
   logic [N_FWD-1:0]  fwd_wen, fwd_pend;
   logic [ADDR_W-1:0] fwd_waddr_a [N_FWD];
   logic [DATA_W-1:0] fwd_wdata_a [N_FWD];
   logic [N_FWD*ADDR_W-1:0] fwd_waddr;
   logic [N_FWD*DATA_W-1:0] fwd_wdata;

   logic              o_valid, o_hazard, o_reg_wen;
   logic [OP_W-1:0]   o_alu_op;
   logic [SEL_W-1:0]  o_alu_sel;
   logic [DATA_W-1:0] o_op0, o_op1;
   logic [ADDR_W-1:0] o_reg_waddr;
   logic [15:0]       o_cnt;

   logic              s_ready, s_valid, s_hazard, s_reg_wen;
   logic [OP_W-1:0]   s_alu_op;
   logic [SEL_W-1:0]  s_alu_sel;
   logic [DATA_W-1:0] s_op0, s_op1;
   logic [ADDR_W-1:0] s_reg_waddr;
   logic [1:0]        s_cnt;

   int checks = 0;
   int failures = 0;
   pl_t exp_q[$];
   int  cnt16 = 0;
   int  cnt2 = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < N_FWD; k++) begin
         fwd_waddr[k*ADDR_W +: ADDR_W] = fwd_waddr_a[k];
         fwd_wdata[k*DATA_W +: DATA_W] = fwd_wdata_a[k];
      end
   end

   id_fwd_pipe #(.CNT_W(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_out),
      .i_reg_0_ren(ren0), .i_reg_1_ren(ren1), .i_reg_0_addr(addr0), .i_reg_1_addr(addr1),
      .i_reg_0_data(data0), .i_reg_1_data(data1), .i_imm(imm), .i_alu_op(alu_op),
      .i_alu_sel(alu_sel), .i_reg_wen(reg_wen), .i_reg_waddr(reg_waddr),
      .i_fwd_wen(fwd_wen), .i_fwd_waddr(fwd_waddr), .i_fwd_wdata(fwd_wdata),
      .i_fwd_pend(fwd_pend), .i_flush(flush), .o_valid(o_valid), .i_ready(ex_ready),
      .o_alu_op(o_alu_op), .o_alu_sel(o_alu_sel), .o_op_reg_0(o_op0), .o_op_reg_1(o_op1),
      .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_hazard(o_hazard),
      .o_stall_cnt(o_cnt));

   id_fwd_pipe #(.CNT_W(2)) dut_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(s_ready),
      .i_reg_0_ren(ren0), .i_reg_1_ren(ren1), .i_reg_0_addr(addr0), .i_reg_1_addr(addr1),
      .i_reg_0_data(data0), .i_reg_1_data(data1), .i_imm(imm), .i_alu_op(alu_op),
      .i_alu_sel(alu_sel), .i_reg_wen(reg_wen), .i_reg_waddr(reg_waddr),
      .i_fwd_wen(fwd_wen), .i_fwd_waddr(fwd_waddr), .i_fwd_wdata(fwd_wdata),
      .i_fwd_pend(fwd_pend), .i_flush(flush), .o_valid(s_valid), .i_ready(ex_ready),
      .o_alu_op(s_alu_op), .o_alu_sel(s_alu_sel), .o_op_reg_0(s_op0), .o_op_reg_1(s_op1),
      .o_reg_wen(s_reg_wen), .o_reg_waddr(s_reg_waddr), .o_hazard(s_hazard),
      .o_stall_cnt(s_cnt));

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference operand lookup: {hazard, value}; youngest matching source wins.
   function automatic logic [DATA_W:0] ref_resolve(input logic ren, input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] rdata);
      if (!ren) return {1'b0, imm};
      if (addr == 0) return '0;
      for (int k = 0; k < N_FWD; k++) begin
         if (fwd_wen[k] && fwd_waddr_a[k] == addr)
            return fwd_pend[k] ? {1'b1, {DATA_W{1'b0}}} : {1'b0, fwd_wdata_a[k]};
      end
      return {1'b0, rdata};
   endfunction

   function automatic pl_t cur_out();
      return '{op: o_alu_op, sel: o_alu_sel, r0: o_op0, r1: o_op1, wen: o_reg_wen, waddr: o_reg_waddr};
   endfunction

   // One clock cycle with the inputs already driven: model the edge, check
   // combinational outputs, enqueue expected payload on accept.
   task automatic step();
      logic [DATA_W:0] r0, r1;
      logic haz, held, rdy, acc;
      @(negedge clk); #2;
      r0 = ref_resolve(ren0, addr0, data0);
      r1 = ref_resolve(ren1, addr1, data1);
      haz  = valid & (r0[DATA_W] | r1[DATA_W]);
      held = (exp_q.size() != 0);
      rdy  = (!held || ex_ready) && !haz && !flush;
      acc  = valid && rdy;
      chk("hazard", o_hazard, haz);
      chk("ready", ready_out, rdy);
      chk("valid", o_valid, held);
      chk("stall_cnt", o_cnt, cnt16);
      chk("stall_cnt_sat", s_cnt, cnt2);
      if (valid && !acc && !flush) begin
         if (cnt16 < 65535) cnt16++;
         if (cnt2 < 3) cnt2++;
      end
      if (flush && held) void'(exp_q.pop_front());
      if (acc) exp_q.push_back('{op: alu_op, sel: alu_sel, r0: r0[DATA_W-1:0],
                                 r1: r1[DATA_W-1:0], wen: reg_wen, waddr: reg_waddr});
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_cnt", o_cnt, 16'd0);
      chk("rst_cnt_sat", s_cnt, 2'd0);
      chk("rst_payload", cur_out(), '0);
      exp_q.delete();
      cnt16 = 0;
      cnt2 = 0;
      #1 rst_n = 1'b1;
   endtask

   task automatic clear_inputs();
      valid = 0; ren0 = 0; ren1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0; imm = 0;
      alu_op = 0; alu_sel = 0; reg_wen = 0; reg_waddr = 0; flush = 0; ex_ready = 1;
      fwd_wen = 0; fwd_pend = 0;
      for (int k = 0; k < N_FWD; k++) begin
         fwd_waddr_a[k] = 0;
         fwd_wdata_a[k] = 0;
      end
   endtask

   task automatic rand_inputs();
      valid = ($urandom_range(0, 3) != 0);
      ren0 = ($urandom_range(0, 4) != 0);
      ren1 = ($urandom_range(0, 4) != 0);
      addr0 = ADDR_W'($urandom_range(0, 3));
      addr1 = ADDR_W'($urandom_range(0, 3));
      data0 = $urandom; data1 = $urandom; imm = $urandom;
      alu_op = OP_W'($urandom); alu_sel = SEL_W'($urandom);
      reg_wen = 1'($urandom); reg_waddr = ADDR_W'($urandom);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 11) == 0);
      for (int k = 0; k < N_FWD; k++) begin
         fwd_wen[k] = 1'($urandom);
         fwd_pend[k] = ($urandom_range(0, 5) == 0);
         fwd_waddr_a[k] = ADDR_W'($urandom_range(0, 3));
         fwd_wdata_a[k] = $urandom;
      end
   endtask

   // Monitor: compares the held payload whenever EX takes it.
   initial begin
      pl_t exp_pl, act_pl;
      forever begin
         @(negedge clk); #4;
         if (rst_n) begin
            act_pl = cur_out();
            if (o_valid && ex_ready && !flush) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL consume_unexpected actual=%0h required=none", act_pl);
               end else begin
                  exp_pl = exp_q.pop_front();
                  if (act_pl !== exp_pl) begin
                     failures++;
                     $display("FAIL payload actual=%0h required=%0h", act_pl, exp_pl);
                  end
               end
            end else if (!o_valid) begin
               checks++;
               if (act_pl !== '0) begin
                  failures++;
                  $display("FAIL bubble_payload actual=%0h required=0", act_pl);
               end
            end
         end
      end
   end

   initial begin
      logic [DATA_W-1:0] snap;
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", o_valid, 1'b0);
      chk("reset_payload", cur_out(), '0);
      chk("reset_cnt", o_cnt, 16'd0);
      rst_n = 1'b1;

      // Forward priority
      valid = 1; ren0 = 1; addr0 = 3; data0 = 32'h5; alu_op = 8'h21; reg_wen = 1; reg_waddr = 9;
      fwd_wen = 2'b11; fwd_waddr_a[0] = 3; fwd_waddr_a[1] = 3;
      fwd_wdata_a[0] = 32'hAAAA0000; fwd_wdata_a[1] = 32'h11;
      step(); chk("fwd_youngest", o_op0, 32'hAAAA0000);
      fwd_wen = 2'b10;
      step(); chk("fwd_older", o_op0, 32'h11);
      fwd_wen = 2'b00;
      step(); chk("fwd_none", o_op0, 32'h5);

      // $zero and immediate
      ren0 = 0; ren1 = 1; addr1 = 0; data1 = 32'h99;
      fwd_wen = 2'b01; fwd_waddr_a[0] = 0; fwd_wdata_a[0] = 32'hFFFF; fwd_pend = 2'b01;
      #1 chk("zero_no_hazard", o_hazard, 1'b0);
      step(); chk("zero_operand", o_op1, 32'h0);
      ren1 = 0; imm = 32'h1234;
      step(); chk("imm_operand", o_op1, 32'h1234);

      // Load-use stall
      do_reset();
      ren0 = 1; addr0 = 7; fwd_wen = 2'b01; fwd_waddr_a[0] = 7; fwd_pend = 2'b01;
      #1 chk("lu_hazard", o_hazard, 1'b1);
      chk("lu_ready", ready_out, 1'b0);
      repeat (3) begin
         step(); chk("lu_bubble", o_valid, 1'b0);
      end
      chk("lu_cnt3", o_cnt, 16'd3);
      fwd_pend = 2'b00; fwd_wdata_a[0] = 32'h42;
      step(); chk("lu_resolved", o_op0, 32'h42);

      // Backpressure: held 0x42 frozen while EX stalls
      ex_ready = 0; fwd_wen = 2'b00; data0 = 32'h77;
      snap = o_op0;
      repeat (4) step();
      chk("bp_frozen", o_op0, snap);
      chk("bp_cnt", o_cnt, 16'd7);
      ex_ready = 1;
      step(); chk("bp_replace", o_op0, 32'h77);

      // Flush
      flush = 1;
      step();
      chk("flush_valid", o_valid, 1'b0);
      chk("flush_op0", o_op0, 32'h0);
      chk("flush_cnt", o_cnt, 16'd7);
      flush = 0;

      // Reset mid-stall and CNT_W=2 saturation
      do_reset();
      step();
      ex_ready = 0;
      repeat (9) step();
      chk("ms_cnt9", o_cnt, 16'd9);
      chk("ms_sat3", s_cnt, 2'd3);
      chk("ms_valid", o_valid, 1'b1);
      do_reset();

      for (int i = 0; i < 600; i++) begin
         rand_inputs();
         step();
         if (i == 300) do_reset();
      end
      clear_inputs();
      ex_ready = 1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/id_fwd_pipe.md
Name: id_fwd_pipe

Overview:
- Parametrised successor to the combinational decode-operand stage: resolves both source operands from the regfile, N_FWD forwarding sources or the immediate, and registers the result into an ID/EX pipeline register.
- Adds what the combinational stage lacks: valid/ready handshake to EX, load-use (pending-data) hazard stall, flush, $zero protection, and a stall counter.
- Sits between instruction decode logic and the execute stage.

Parameters:
DATA_W, 32, operand/register data width
ADDR_W, 5, register address width
N_FWD, 2, number of forwarding sources; index 0 = youngest, highest priority
OP_W, 8, alu_op width
SEL_W, 3, alu_sel width
CNT_W, 16, stall counter width

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  decoded instruction present
o_ready  out  1  stage accepts instruction this cycle
i_reg_0_ren / i_reg_1_ren  in  1 each  operand port read enables
i_reg_0_addr / i_reg_1_addr  in  ADDR_W each  operand register addresses
i_reg_0_data / i_reg_1_data  in  DATA_W each  regfile read data
i_imm  in  DATA_W  immediate, used when the port read enable is 0
i_alu_op  in  OP_W;  i_alu_sel  in  SEL_W;  i_reg_wen  in  1;  i_reg_waddr  in  ADDR_W  decode payload
i_fwd_wen  in  N_FWD  forwarding source write enables
i_fwd_waddr  in  N_FWD*ADDR_W  forwarding destination addresses, source k at [k*ADDR_W +: ADDR_W]
i_fwd_wdata  in  N_FWD*DATA_W  forwarding data, packed the same way
i_fwd_pend  in  N_FWD  source k data not yet available (load in flight)
i_flush  in  1  discard held and incoming instruction
o_valid  out  1  ID/EX register holds valid instruction
i_ready  in  1  EX consumes output this cycle
o_alu_op  out  OP_W;  o_alu_sel  out  SEL_W;  o_op_reg_0 / o_op_reg_1  out  DATA_W each;  o_reg_wen  out  1;  o_reg_waddr  out  ADDR_W  registered payload
o_hazard  out  1  combinational: i_valid and either operand hits a pending source
o_stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Operand resolve, per port p, combinational:
  - ren=0 -> i_imm.
  - ren=1 and addr=0 -> 0. Never forwarded, never hazard.
  - Otherwise scan k=0..N_FWD-1. The first k with wen[k]=1 and waddr[k]=addr wins.
    - Winner pend[k]=1 -> hazard_p=1.
    - Else -> wdata[k].
  - No match -> i_reg_p_data.
  - Older sources never override younger ones, even when the younger one is pending.
- o_hazard = i_valid & (hazard_0 | hazard_1).
- o_ready = (!o_valid | i_ready) & !o_hazard & !i_flush.
  - o_ready may depend combinationally on i_valid/fwd inputs.
  - i_valid must not depend on o_ready.
- accept = i_valid & o_ready.
- Register update, priority order:
  1. i_flush: o_valid<=0, payload<=0.
  2. accept: payload<=resolved values, o_valid<=1.
  3. o_valid & i_ready: o_valid<=0, payload<=0 (NOP bubble).
  4. Else hold.
- Stability: while o_valid=1 and i_ready=0, all outputs hold unchanged.
- Hazard with a drained output emits a bubble: o_valid=0, payload 0. The instruction is re-presented by the producer.
- Latency: accept at edge n -> o_valid=1 after edge n. Full throughput, 1 instr/cycle, when i_ready=1 and no hazard.
- o_stall_cnt += 1 on each edge where i_valid & !accept & !i_flush. Saturates at 2^CNT_W-1, never wraps.
- Reset (async assert, any time including mid-stall):
  - o_valid=0, o_alu_op/o_alu_sel/o_op_reg_0/o_op_reg_1/o_reg_wen/o_reg_waddr=0, o_stall_cnt=0.
  - Held instruction discarded.
  - Combinational o_hazard and o_ready still follow inputs.
- Simultaneous flush and accept: flush wins, nothing loaded, no stall count.
- Simultaneous consume and accept: new payload replaces old in the same edge.

Test Plan:
1. Forward priority: N_FWD=2, ren0=1 addr0=3, src0 {wen=1, waddr=3, wdata=0xAAAA0000}, src1 {wen=1, waddr=3, wdata=0x11}, regfile=0x5 -> o_op_reg_0=0xAAAA0000 one edge after accept. Drop src0 wen -> 0x11. Drop both -> 0x5.
2. $zero and immediate: addr1=0, src0 {waddr=0, wdata=0xFFFF, pend=1} -> o_op_reg_1=0, o_hazard=0. ren1=0, i_imm=0x1234 -> o_op_reg_1=0x1234.
3. Load-use stall: src0 {waddr=7, pend=1}, addr0=7, i_valid=1 for 3 cycles -> o_hazard=1, o_ready=0, bubble output, o_stall_cnt=3. pend drops with wdata=0x42 -> accept, o_op_reg_0=0x42.
4. Backpressure: fill stage, i_ready=0 for 4 cycles with new i_valid -> outputs frozen, o_stall_cnt+4. i_ready=1 -> next instruction loaded the same edge.
5. Flush: o_valid=1, assert i_flush with i_valid=1 -> next cycle o_valid=0, payload 0, counter unchanged.
6. Reset mid-stall: o_stall_cnt=9, o_valid=1; pulse i_rst_n low between edges -> immediate o_valid=0, o_stall_cnt=0. CNT_W=2 saturation: 5 stalls -> o_stall_cnt=3.
